data_pack: RTL
==============

DATA_PACK -- requirements
Module: data_pack

Interface
REQ-001 SHALL have parameter PIXEL_BIT, default 32: width of one pixel.
REQ-002 SHALL have parameter PACK_BIT, default 64: width of one packed word.
REQ-003 SHALL have parameter FIFO_WIDTH, default 10: width of word-index and y coordinates.
REQ-004 SHALL derive PACK_DIV = PACK_BIT/PIXEL_BIT; legal only for PACK_BIT a multiple of PIXEL_BIT and 2 <= PACK_DIV <= 16.
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 in_pclk  input  1  sole clock; all logic on rising edge.
REQ-007 in_rstn  input  1  synchronous active-low reset.
REQ-008 in_y  input  FIFO_WIDTH  line number of the current pixel.
REQ-009 in_valid  input  1  pixel qualifier; a pixel is accepted only when in_valid and in_de are both 1.
REQ-010 in_de, in_hs, in_vs  input  1 each  video timing.
REQ-011 in_data  input  PIXEL_BIT  pixel value.
REQ-012 out_x  output  FIFO_WIDTH  word index within the line.
REQ-013 out_y  output  FIFO_WIDTH  in_y of the word's first pixel.
REQ-014 out_valid  output  1  one-cycle strobe per packed word.
REQ-015 out_de, out_hs, out_vs  output  1 each  in_de/in_hs/in_vs delayed by exactly 2 cycles.
REQ-016 out_data  output  PACK_BIT  packed word.

Function
REQ-017 SHALL keep a pixel counter pcnt (4 bits), 0..PACK_DIV-1, incremented once per accepted pixel, wrapping to 0 after PACK_DIV-1.
REQ-018 SHALL place the accepted pixel at bits [PIXEL_BIT*(pcnt+1)-1 : PIXEL_BIT*pcnt]; pixel 0 is in the LSBs.
REQ-019 SHALL, on accepting a pixel with pcnt == PACK_DIV-1, present the full word on out_data with out_valid=1 in the next cycle (latency 1).
REQ-020 SHALL hold pcnt and the partial word unchanged while in_de=1 and in_valid=0; gaps do not emit words.
REQ-021 SHALL ignore in_valid while in_de=0.
REQ-022 SHALL flush on the first cycle with in_de=0 after in_de=1 (the falling edge) if pcnt != 0: next cycle out_valid=1, with unfilled slots zero; pcnt then returns to 0.
REQ-023 SHALL emit no word at the falling edge if pcnt == 0.
REQ-024 SHALL give out_x = 0 for the first word of each line, then +1 per emitted word (flush included), wrapping modulo 2^FIFO_WIDTH; index cleared on the in_de falling edge after any flush.
REQ-025 SHALL capture out_y from in_y when pcnt == 0 pixel is accepted; out_y, out_x, out_data held between strobes.
REQ-026 SHALL guarantee every out_valid strobe lies inside the out_de=1 window (follows from REQ-015/019/022 with PACK_DIV >= 2).
REQ-027 SHALL treat a new in_de rising edge in the flush cycle as a new line: flush the old word first, and accept the new pixel into slot 0.

Reset
REQ-028 SHALL, while in_rstn=0 at a clock edge, clear pcnt, word index, partial word, the sync delay lines and all outputs to 0 (out_valid=0, out_de/hs/vs=0, out_x=out_y=0, out_data=0).
REQ-029 SHALL discard any partial word on reset mid-line; no flush occurs after reset release.
REQ-030 SHALL, after release, treat in_de already 1 as a line in progress (no rising edge required) and accept pixels immediately.

Verification
REQ-031 Defaults, in_de high 8 cycles, in_valid=1, pixels 1..8 -> 4 strobes, out_data 0x00000002_00000001 .. 0x00000008_00000007, out_x 0..3, each 1 cycle after the 2nd pixel of the pair.
REQ-032 Line of 5 pixels (A..E) -> 3 strobes; last out_data = 0x00000000_0000000E, one cycle after in_de falls, out_x=2, out_de still 1.
REQ-033 in_valid toggled 1/0 during de with 4 pixels -> 2 words, identical data to the gap-free case, no extra strobes.
REQ-034 in_vs/in_hs/in_de arbitrary patterns -> outputs equal inputs delayed exactly 2 cycles; second line restarts out_x at 0 and out_y = new in_y.
REQ-035 in_rstn pulsed low after 3 pixels, then a 4-pixel line -> no flush of old data; first word = new pixels 0/1, out_x=0.
REQ-036 PACK_BIT=128, PIXEL_BIT=32, line of 1030 words -> out_x wraps 1023 -> 0; data correct at wrap.

Source files
------------

// File: rtl/data_pack.sv
// Packs PACK_DIV consecutive accepted pixels of a video line into one wide word,
// flushing a partial word at the end of the line; sync signals are delayed to match.
module data_pack #(
    parameter int PIXEL_BIT  = 32,
    parameter int PACK_BIT   = 64,
    parameter int FIFO_WIDTH = 10
) (
    input  logic                  in_pclk,
    input  logic                  in_rstn,
    input  logic [FIFO_WIDTH-1:0] in_y,
    input  logic                  in_valid,
    input  logic                  in_de,
    input  logic                  in_hs,
    input  logic                  in_vs,
    input  logic [PIXEL_BIT-1:0]  in_data,
    output logic [FIFO_WIDTH-1:0] out_x,
    output logic [FIFO_WIDTH-1:0] out_y,
    output logic                  out_valid,
    output logic                  out_de,
    output logic                  out_hs,
    output logic                  out_vs,
    output logic [PACK_BIT-1:0]   out_data
);

    localparam int              PACK_DIV  = PACK_BIT / PIXEL_BIT;
    localparam logic [3:0]      LAST_SLOT = 4'(PACK_DIV - 1);
    localparam logic [FIFO_WIDTH-1:0] X_ONE = {{(FIFO_WIDTH-1){1'b0}}, 1'b1};

    logic [3:0]            pcnt_reg;
    logic [PACK_BIT-1:0]   word_reg;
    logic [PACK_BIT-1:0]   word_next;
    logic [FIFO_WIDTH-1:0] xcnt_reg;
    logic [FIFO_WIDTH-1:0] ycap_reg;
    logic                  de_prev_reg;
    logic [2:0]            sync_d1_reg;
    logic [2:0]            sync_d2_reg;
    logic                  out_valid_reg;
    logic [FIFO_WIDTH-1:0] out_x_reg;
    logic [FIFO_WIDTH-1:0] out_y_reg;
    logic [PACK_BIT-1:0]   out_data_reg;

    logic accept;
    logic de_fall;
    logic word_full;

    assign accept    = in_valid & in_de;
    assign de_fall   = de_prev_reg & ~in_de;
    assign word_full = accept && (pcnt_reg == LAST_SLOT);

    // The incoming pixel replaces only the slot selected by the pixel counter.
    generate
        for (genvar gi = 0; gi < PACK_DIV; gi++) begin : g_slot
            assign word_next[gi*PIXEL_BIT +: PIXEL_BIT] =
                (pcnt_reg == 4'(gi)) ? in_data : word_reg[gi*PIXEL_BIT +: PIXEL_BIT];
        end
    endgenerate

    always_ff @(posedge in_pclk) begin
        if (!in_rstn) begin
            pcnt_reg      <= '0;
            word_reg      <= '0;
            xcnt_reg      <= '0;
            ycap_reg      <= '0;
            de_prev_reg   <= 1'b0;
            sync_d1_reg   <= '0;
            sync_d2_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            out_data_reg  <= '0;
        end else begin
            de_prev_reg   <= in_de;
            sync_d1_reg   <= {in_vs, in_hs, in_de};
            sync_d2_reg   <= sync_d1_reg;
            out_valid_reg <= 1'b0;

            if (accept) begin
                if (pcnt_reg == 4'd0) begin
                    ycap_reg <= in_y;
                end
                if (word_full) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= word_next;
                    out_x_reg     <= xcnt_reg;
                    out_y_reg     <= ycap_reg;
                    xcnt_reg      <= xcnt_reg + X_ONE;
                    word_reg      <= '0;
                    pcnt_reg      <= 4'd0;
                end else begin
                    word_reg <= word_next;
                    pcnt_reg <= pcnt_reg + 4'd1;
                end
            end else if (de_fall) begin
                // End of line: emit any partial word (empty slots are already zero).
                if (pcnt_reg != 4'd0) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= word_reg;
                    out_x_reg     <= xcnt_reg;
                    out_y_reg     <= ycap_reg;
                end
                word_reg <= '0;
                pcnt_reg <= 4'd0;
                xcnt_reg <= '0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_x     = out_x_reg;
    assign out_y     = out_y_reg;
    assign out_data  = out_data_reg;
    assign {out_vs, out_hs, out_de} = sync_d2_reg;

endmodule
